// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Registered, multi-cycle control unit that drives the ID/EX control fields.
// Single-cycle opcodes decode directly. Multi-word load/store (LDM/STM)
// expands into BEATS back-to-back micro-ops, and seq_busy holds fetch/decode
// while the expansion runs. hazard_stall inserts a bubble. exception squashes
// the current operation and returns the sequencer to IDLE.
//
// Optional feature: define ILLEGAL_OP_TRAP_EN to pulse illegal_op for one
// cycle when an opcode outside 0-15 is accepted. Without the macro such
// opcodes are a silent NOP and illegal_op is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   opcode       opcode of the instruction in decode
//   id_valid     decode slot holds a real instruction
//   hazard_stall bubble request from the hazard unit
//   exception    flush request (highest priority)
//   RegWr, ExtOp, MemRd, MemWr, WBdata, Data_write   registered 1-bit controls
//   ALUOp        registered ALU operation
//   RegDst, RegReadB, ALUSrc                         registered 2-bit selects
//   beat_idx     beat number of the current micro-op (0 for single ops)
//   seq_busy     combinational; 1 = hold PC and IF/ID this cycle
//   illegal_op   registered one-cycle trap pulse (ILLEGAL_OP_TRAP_EN only)
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPC_W   = 6,
    parameter int BEATS   = 2,
    parameter int BEAT_W  = ($clog2(BEATS) > 0 ? $clog2(BEATS) : 1),
    parameter int LDM_OPC = 8,
    parameter int STM_OPC = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              id_valid,
    input  logic              hazard_stall,
    input  logic              exception,
    output logic              RegWr,
    output logic              ExtOp,
    output logic              MemRd,
    output logic              MemWr,
    output logic              WBdata,
    output logic              Data_write,
    output logic [2:0]        ALUOp,
    output logic [1:0]        RegDst,
    output logic [1:0]        RegReadB,
    output logic [1:0]        ALUSrc,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              seq_busy,
    output logic              illegal_op
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_MULTI = 1'b1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic              MULTI_EN  = (BEATS > 1);

    // Control bundle packing, MSB first:
    // RegWr, ExtOp, MemRd, MemWr, WBdata, Data_write, ALUOp[2:0],
    // RegDst[1:0], RegReadB[1:0], ALUSrc[1:0]
    function automatic logic [14:0] single_ctrl(input logic [3:0] op);
        case (op)
            4'd0:    single_ctrl = 15'b1_0_0_0_0_0_000_00_00_00; // OR
            4'd1:    single_ctrl = 15'b1_0_0_0_0_0_001_00_00_00; // ADD
            4'd2:    single_ctrl = 15'b1_0_0_0_0_0_010_00_00_00; // SUB
            4'd3:    single_ctrl = 15'b1_0_0_0_0_0_011_00_00_00; // CMP
            4'd4:    single_ctrl = 15'b1_0_0_0_0_0_000_00_00_01; // ORI
            4'd5:    single_ctrl = 15'b1_1_0_0_0_0_001_00_00_01; // ADDI
            4'd6:    single_ctrl = 15'b1_1_1_0_1_0_001_00_00_01; // LW
            4'd7:    single_ctrl = 15'b0_1_0_1_0_0_001_00_01_01; // SW
            4'd10, 4'd11, 4'd12:
                     single_ctrl = 15'b0_1_0_0_0_0_100_00_00_00; // branch
            4'd13, 4'd14:
                     single_ctrl = 15'b0_1_0_0_0_0_000_00_00_00; // jump
            4'd15:   single_ctrl = 15'b1_1_0_0_0_1_000_10_00_00; // CLL
            default: single_ctrl = '0;
        endcase
    endfunction

    // Beat 0 addresses/selects the first word; later beats use the
    // incremented base and the alternate register port.
    function automatic logic [14:0] beat_ctrl(input logic stm, input logic first);
        if (!stm)
            beat_ctrl = first ? 15'b1_1_1_0_1_0_001_01_00_10
                              : 15'b1_1_1_0_1_0_001_00_00_01;
        else
            beat_ctrl = first ? 15'b0_1_0_1_0_0_001_10_10_10
                              : 15'b0_1_0_1_0_0_001_01_01_01;
    endfunction

    logic              state_reg, state_next;
    logic [BEAT_W-1:0] cnt_reg, cnt_next;
    logic              is_stm_reg, is_stm_next;
    logic [14:0]       ctrl_reg, ctrl_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              busy_raw;

    logic op_is_ldm, op_is_stm, op_in_range;
    assign op_is_ldm   = (opcode == OPC_W'(LDM_OPC));
    assign op_is_stm   = (opcode == OPC_W'(STM_OPC));
    assign op_in_range = ((opcode >> 4) == '0);

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_reg, illegal_next;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        is_stm_next = is_stm_reg;
        ctrl_next   = '0;
        beat_next   = '0;
        busy_raw    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_next = 1'b0;
`endif
        // Busy in MULTI ignores hazard_stall so decode stays held across a bubble.
        if (state_reg == S_MULTI)
            busy_raw = (cnt_reg != LAST_BEAT);

        if (exception) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else if (hazard_stall) begin
            // bubble only; sequencing state holds
        end else if (state_reg == S_MULTI) begin
            // Micro-ops come from the latched opcode, not the decode slot.
            ctrl_next = beat_ctrl(is_stm_reg, 1'b0);
            beat_next = cnt_reg;
            if (cnt_reg == LAST_BEAT) begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + BEAT_W'(1);
            end
        end else if (id_valid) begin
            if (op_is_ldm || op_is_stm) begin
                is_stm_next = op_is_stm;
                ctrl_next   = beat_ctrl(op_is_stm, 1'b1);
                if (MULTI_EN) begin
                    state_next = S_MULTI;
                    cnt_next   = BEAT_W'(1);
                    busy_raw   = 1'b1;
                end
            end else if (op_in_range) begin
                ctrl_next = single_ctrl(opcode[3:0]);
            end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                illegal_next = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            is_stm_reg <= 1'b0;
            ctrl_reg   <= '0;
            beat_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            is_stm_reg <= is_stm_next;
            ctrl_reg   <= ctrl_next;
            beat_reg   <= beat_next;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_reg <= 1'b0;
        else
            illegal_reg <= illegal_next;
    end
    assign illegal_op = illegal_reg;
`else
    assign illegal_op = 1'b0;
`endif

    assign {RegWr, ExtOp, MemRd, MemWr, WBdata, Data_write,
            ALUOp, RegDst, RegReadB, ALUSrc} = ctrl_reg;
    assign beat_idx = beat_reg;
    // Exception and reset both release fetch immediately.
    assign seq_busy = busy_raw & ~exception & ~reset;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    // Expected control bundles, packed as
    // {RegWr,ExtOp,MemRd,MemWr,WBdata,Data_write,ALUOp,RegDst,RegReadB,ALUSrc}
    localparam logic [14:0] NOP    = 15'b0;
    localparam logic [14:0] E_ADD  = 15'b1_0_0_0_0_0_001_00_00_00;
    localparam logic [14:0] E_ORI  = 15'b1_0_0_0_0_0_000_00_00_01;
    localparam logic [14:0] E_LW   = 15'b1_1_1_0_1_0_001_00_00_01;
    localparam logic [14:0] LDM_B0 = 15'b1_1_1_0_1_0_001_01_00_10;
    localparam logic [14:0] LDM_BK = 15'b1_1_1_0_1_0_001_00_00_01;
    localparam logic [14:0] STM_B0 = 15'b0_1_0_1_0_0_001_10_10_10;
    localparam logic [14:0] STM_BK = 15'b0_1_0_1_0_0_001_01_01_01;

    localparam logic [5:0] OP_ADD = 6'd1, OP_ORI = 6'd4, OP_LW = 6'd6;
    localparam logic [5:0] OP_LDM = 6'd8, OP_STM = 6'd9;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = '0;
    logic id_valid = 1'b0, hazard_stall = 1'b0, exception = 1'b0;

    logic [14:0] c1, c2, c4;
    logic [0:0]  b1, b2;
    logic [1:0]  b4;
    logic busy1, busy2, busy4, ill1, ill2, ill4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer #(.BEATS(1)) u1 (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .exception(exception),
        .RegWr(c1[14]), .ExtOp(c1[13]), .MemRd(c1[12]), .MemWr(c1[11]),
        .WBdata(c1[10]), .Data_write(c1[9]), .ALUOp(c1[8:6]), .RegDst(c1[5:4]),
        .RegReadB(c1[3:2]), .ALUSrc(c1[1:0]), .beat_idx(b1), .seq_busy(busy1),
        .illegal_op(ill1));

    control_sequencer #(.BEATS(2)) u2 (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .exception(exception),
        .RegWr(c2[14]), .ExtOp(c2[13]), .MemRd(c2[12]), .MemWr(c2[11]),
        .WBdata(c2[10]), .Data_write(c2[9]), .ALUOp(c2[8:6]), .RegDst(c2[5:4]),
        .RegReadB(c2[3:2]), .ALUSrc(c2[1:0]), .beat_idx(b2), .seq_busy(busy2),
        .illegal_op(ill2));

    control_sequencer #(.BEATS(4)) u4 (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .exception(exception),
        .RegWr(c4[14]), .ExtOp(c4[13]), .MemRd(c4[12]), .MemWr(c4[11]),
        .WBdata(c4[10]), .Data_write(c4[9]), .ALUOp(c4[8:6]), .RegDst(c4[5:4]),
        .RegReadB(c4[3:2]), .ALUSrc(c4[1:0]), .beat_idx(b4), .seq_busy(busy4),
        .illegal_op(ill4));

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; opcode = '0; id_valid = 1'b0; hazard_stall = 1'b0; exception = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (c4 !== NOP) begin errors++; $display("FAIL reset_ctrl: got %h want %h", c4, NOP); end
        checks++; if (b4 !== 2'd0) begin errors++; $display("FAIL reset_beat: got %0d want 0", b4); end
        opcode = OP_LDM; id_valid = 1'b1;
        #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL reset_ldm_busy: got %b want 1", busy4); end
        @(negedge clk);
        checks++; if (c4 !== LDM_B0) begin errors++; $display("FAIL reset_ldm_b0: got %h want %h", c4, LDM_B0); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (c4 !== NOP) begin errors++; $display("FAIL reset_mid_ctrl: got %h want %h", c4, NOP); end
        checks++; if (b4 !== 2'd0) begin errors++; $display("FAIL reset_mid_beat: got %0d want 0", b4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy4); end
        @(negedge clk);
        reset = 1'b0; opcode = OP_ADD; id_valid = 1'b1;
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_add_busy: got %b want 0", busy4); end
        @(negedge clk);
        checks++; if (c4 !== E_ADD) begin errors++; $display("FAIL reset_add: got %h want %h", c4, E_ADD); end
        id_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_ldm_beats2();
        do_reset();
        opcode = OP_LDM; id_valid = 1'b1;
        #1;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL ldm2_busy_T: got %b want 1", busy2); end
        @(negedge clk);
        checks++; if (c2 !== LDM_B0) begin errors++; $display("FAIL ldm2_b0: got %h want %h", c2, LDM_B0); end
        checks++; if (b2 !== 1'd0) begin errors++; $display("FAIL ldm2_idx0: got %0d want 0", b2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ldm2_busy_T1: got %b want 0", busy2); end
        @(negedge clk);
        checks++; if (c2 !== LDM_BK) begin errors++; $display("FAIL ldm2_b1: got %h want %h", c2, LDM_BK); end
        checks++; if (b2 !== 1'd1) begin errors++; $display("FAIL ldm2_idx1: got %0d want 1", b2); end
        opcode = OP_ADD;
        @(negedge clk);
        checks++; if (c2 !== E_ADD) begin errors++; $display("FAIL ldm2_next_add: got %h want %h", c2, E_ADD); end
        checks++; if (b2 !== 1'd0) begin errors++; $display("FAIL ldm2_add_idx: got %0d want 0", b2); end
        id_valid = 1'b0;
        $display("test_ldm_beats2 done");
    endtask

    task automatic test_stm_stall();
        do_reset();
        opcode = OP_STM; id_valid = 1'b1;
        #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL stm4_busy0: got %b want 1", busy4); end
        @(negedge clk);
        checks++; if (c4 !== STM_B0 || b4 !== 2'd0) begin errors++; $display("FAIL stm4_b0: got %h/%0d want %h/0", c4, b4, STM_B0); end
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL stm4_busy1: got %b want 1", busy4); end
        @(negedge clk);
        checks++; if (c4 !== STM_BK || b4 !== 2'd1) begin errors++; $display("FAIL stm4_b1: got %h/%0d want %h/1", c4, b4, STM_BK); end
        hazard_stall = 1'b1;
        #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL stm4_busy_stall: got %b want 1", busy4); end
        @(negedge clk);
        checks++; if (c4 !== NOP || b4 !== 2'd0) begin errors++; $display("FAIL stm4_bubble: got %h/%0d want %h/0", c4, b4, NOP); end
        hazard_stall = 1'b0;
        #1;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL stm4_busy_resume: got %b want 1", busy4); end
        @(negedge clk);
        checks++; if (c4 !== STM_BK || b4 !== 2'd2) begin errors++; $display("FAIL stm4_b2: got %h/%0d want %h/2", c4, b4, STM_BK); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL stm4_busy_last: got %b want 0", busy4); end
        id_valid = 1'b0;
        @(negedge clk);
        checks++; if (c4 !== STM_BK || b4 !== 2'd3) begin errors++; $display("FAIL stm4_b3: got %h/%0d want %h/3", c4, b4, STM_BK); end
        @(negedge clk);
        checks++; if (c4 !== NOP) begin errors++; $display("FAIL stm4_done: got %h want %h", c4, NOP); end
        $display("test_stm_stall done");
    endtask

    task automatic test_exception();
        do_reset();
        opcode = OP_LDM; id_valid = 1'b1;
        @(negedge clk);
        checks++; if (c4 !== LDM_B0) begin errors++; $display("FAIL exc_b0: got %h want %h", c4, LDM_B0); end
        exception = 1'b1;
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL exc_busy: got %b want 0", busy4); end
        @(negedge clk);
        checks++; if (c4 !== NOP || b4 !== 2'd0) begin errors++; $display("FAIL exc_nop: got %h/%0d want %h/0", c4, b4, NOP); end
        exception = 1'b0; opcode = OP_ORI;
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL exc_ori_busy: got %b want 0", busy4); end
        @(negedge clk);
        checks++; if (c4 !== E_ORI || b4 !== 2'd0) begin errors++; $display("FAIL exc_ori: got %h/%0d want %h/0", c4, b4, E_ORI); end
        id_valid = 1'b0;
        $display("test_exception done");
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'd40; id_valid = 1'b1;
        @(negedge clk);
        checks++; if (c2 !== NOP) begin errors++; $display("FAIL ill_ctrl: got %h want %h", c2, NOP); end
        checks++; if (ill2 !== EXP_ILL) begin errors++; $display("FAIL ill_pulse: got %b want %b", ill2, EXP_ILL); end
        opcode = OP_ADD;
        @(negedge clk);
        checks++; if (ill2 !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b want 0", ill2); end
        checks++; if (c2 !== E_ADD) begin errors++; $display("FAIL ill_after_add: got %h want %h", c2, E_ADD); end
        id_valid = 1'b0;
        $display("test_illegal done");
    endtask

    task automatic test_idle_and_single_beat();
        do_reset();
        opcode = OP_LW; id_valid = 1'b0;
        @(negedge clk);
        checks++; if (c2 !== NOP) begin errors++; $display("FAIL lw_invalid: got %h want %h", c2, NOP); end
        id_valid = 1'b1;
        @(negedge clk);
        checks++; if (c2 !== E_LW) begin errors++; $display("FAIL lw_valid: got %h want %h", c2, E_LW); end
        opcode = OP_STM;
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b1_busy0: got %b want 0", busy1); end
        @(negedge clk);
        checks++; if (c1 !== STM_B0 || b1 !== 1'd0) begin errors++; $display("FAIL b1_stm: got %h/%0d want %h/0", c1, b1, STM_B0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b1_busy1: got %b want 0", busy1); end
        id_valid = 1'b0;
        @(negedge clk);
        checks++; if (c1 !== NOP) begin errors++; $display("FAIL b1_after: got %h want %h", c1, NOP); end
        $display("test_idle_and_single_beat done");
    endtask

    task automatic test_decode();
        logic [5:0]  ops  [16] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                   6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd20, 6'd63};
        logic [14:0] exps [16] = '{15'b1_0_0_0_0_0_000_00_00_00, 15'b1_0_0_0_0_0_001_00_00_00,
                                   15'b1_0_0_0_0_0_010_00_00_00, 15'b1_0_0_0_0_0_011_00_00_00,
                                   15'b1_0_0_0_0_0_000_00_00_01, 15'b1_1_0_0_0_0_001_00_00_01,
                                   15'b1_1_1_0_1_0_001_00_00_01, 15'b0_1_0_1_0_0_001_00_01_01,
                                   15'b0_1_0_0_0_0_100_00_00_00, 15'b0_1_0_0_0_0_100_00_00_00,
                                   15'b0_1_0_0_0_0_100_00_00_00, 15'b0_1_0_0_0_0_000_00_00_00,
                                   15'b0_1_0_0_0_0_000_00_00_00, 15'b1_1_0_0_0_1_000_10_00_00,
                                   15'b0, 15'b0};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            opcode = ops[i]; id_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (c2 !== exps[i]) begin errors++; $display("FAIL decode_op%0d: got %h want %h", ops[i], c2, exps[i]); end
        end
        id_valid = 1'b0;
        $display("test_decode done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        opcode = OP_LDM; id_valid = 1'b1;
        @(negedge clk);
        checks++; if (c2 !== LDM_B0) begin errors++; $display("FAIL b2b_b0a: got %h want %h", c2, LDM_B0); end
        @(negedge clk);
        // second LDM arrives in decode as the first one finishes
        checks++; if (c2 !== LDM_BK || b2 !== 1'd1) begin errors++; $display("FAIL b2b_b1a: got %h/%0d want %h/1", c2, b2, LDM_BK); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy2); end
        @(negedge clk);
        checks++; if (c2 !== LDM_B0 || b2 !== 1'd0) begin errors++; $display("FAIL b2b_b0b: got %h/%0d want %h/0", c2, b2, LDM_B0); end
        opcode = OP_STM;
        @(negedge clk);
        checks++; if (c2 !== LDM_BK || b2 !== 1'd1) begin errors++; $display("FAIL b2b_b1b: got %h/%0d want %h/1", c2, b2, LDM_BK); end
        @(negedge clk);
        checks++; if (c2 !== STM_B0) begin errors++; $display("FAIL b2b_stm: got %h want %h", c2, STM_B0); end
        id_valid = 1'b0;
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_ldm_beats2();
        test_stm_stall();
        test_exception();
        test_illegal();
        test_idle_and_single_beat();
        test_decode();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
